// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter.
// State encoding and parameter defaults.
package bus_arbiter_pkg;

    localparam int BG_TIMEOUT_DEF  = 255;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQUEST  = 3'd1;
    localparam logic [2:0] ST_WAIT_BUS = 3'd2;
    localparam logic [2:0] ST_OWN      = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

endpackage

// File: rtl/bus_arbiter_sync_ff.sv
// Single-bit multi-flop synchronizer for async bus inputs.
// Resets to 1 so that active-low strobes read as idle.
module sync_ff
    import bus_arbiter_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving two DMA masters the CPU bus
// via the br/bg/bgack handshake, with grant timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int BG_TIMEOUT  = BG_TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       por_n,
    input  logic [1:0] req_n,
    input  logic       bg_n,
    input  logic       as_n,
    input  logic       dtack_n,
    input  logic       bgack_in_n,
    output logic       br_n,
    output logic       bgack_n,
    output logic [1:0] grant_n,
    output logic       timeout
);

    localparam logic [15:0] TO_LIMIT = 16'(BG_TIMEOUT);
    localparam logic [3:0]  WARM_MAX = 4'(SYNC_STAGES);

    logic        s_bg;
    logic        s_as;
    logic        s_dtack;
    logic        s_bgack;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [15:0] cnt_inc;
    logic        winner;
    logic        winner_nx;
    logic        last_grant;
    logic        last_nx;
    logic        pick;
    logic        bus_free;
    logic        arb_en;
    logic [3:0]  warm;

    logic        br_q;
    logic        br_nx;
    logic        bgack_q;
    logic        bgack_nx;
    logic [1:0]  grant_q;
    logic [1:0]  grant_nx;
    logic        timeout_q;
    logic        timeout_nx;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bg (
        .clk   (clk),
        .rst_n (por_n),
        .d     (bg_n),
        .q     (s_bg)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_as (
        .clk   (clk),
        .rst_n (por_n),
        .d     (as_n),
        .q     (s_as)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dtack (
        .clk   (clk),
        .rst_n (por_n),
        .d     (dtack_n),
        .q     (s_dtack)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bgack (
        .clk   (clk),
        .rst_n (por_n),
        .d     (bgack_in_n),
        .q     (s_bgack)
    );

    assign bus_free = s_as & s_dtack & s_bgack;
    assign arb_en   = (warm == WARM_MAX);
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // Tie goes to the master not granted last; else the lone requester.
    always_comb begin
        if (req_n == 2'b00) begin
            pick = ~last_grant;
        end else begin
            pick = req_n[0];
        end
    end

    // Next-state logic and registered output targets.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        winner_nx  = winner;
        last_nx    = last_grant;
        timeout_nx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arb_en && req_n != 2'b11) begin
                    winner_nx = pick;
                    cnt_nx    = '0;
                    state_nx  = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                cnt_nx = cnt_inc;
                if (req_n[winner]) begin
                    state_nx = ST_IDLE;
                end else if (!s_bg) begin
                    state_nx = ST_WAIT_BUS;
                end else if (cnt_inc >= TO_LIMIT) begin
                    state_nx   = ST_IDLE;
                    timeout_nx = 1'b1;
                end
            end
            ST_WAIT_BUS: begin
                if (s_bg) begin
                    state_nx = ST_REQUEST;
                    cnt_nx   = '0;
                end else if (bus_free) begin
                    state_nx = ST_OWN;
                    last_nx  = winner;
                end
            end
            ST_OWN: begin
                if (req_n[winner]) begin
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Outputs follow the next state so they change on the entry edge.
    always_comb begin
        br_nx    = (state_nx == ST_REQUEST) || (state_nx == ST_WAIT_BUS);
        bgack_nx = (state_nx == ST_OWN);
        grant_nx = 2'b11;
        if (state_nx == ST_OWN) begin
            grant_nx[winner_nx] = 1'b0;
        end
    end

    // State, counter, round-robin memory and output registers.
    always_ff @(posedge clk or negedge por_n) begin
        if (!por_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            winner     <= 1'b0;
            last_grant <= 1'b1;
            br_q       <= 1'b0;
            bgack_q    <= 1'b0;
            grant_q    <= 2'b11;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            winner     <= winner_nx;
            last_grant <= last_nx;
            br_q       <= br_nx;
            bgack_q    <= bgack_nx;
            grant_q    <= grant_nx;
            timeout_q  <= timeout_nx;
        end
    end

    // Hold off arbitration until the synchronizers hold real samples.
    always_ff @(posedge clk or negedge por_n) begin
        if (!por_n) begin
            warm <= '0;
        end else if (warm != WARM_MAX) begin
            warm <= warm + 4'd1;
        end
    end

    assign br_n    = br_q    ? 1'b0 : 1'bz;
    assign bgack_n = bgack_q ? 1'b0 : 1'bz;
    assign grant_n = grant_q;
    assign timeout = timeout_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters: BG_TIMEOUT, default 255, max clk cycles from br_n assertion to bg_n before abort; SYNC_STAGES, default 2, synchronizer depth on CPU bus inputs.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 por_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 req_n  input  2  DMA master bus requests; held low for the whole tenure.
REQ-005 bg_n  input  1  CPU bus grant, asynchronous.
REQ-006 as_n  input  1  CPU address strobe, asynchronous.
REQ-007 dtack_n  input  1  bus DTACK, asynchronous.
REQ-008 bgack_in_n  input  1  wired bus BGACK, other masters included, asynchronous.
REQ-009 br_n  output  1  bus request to CPU; driven 0 or Z.
REQ-010 bgack_n  output  1  bus grant acknowledge; driven 0 or Z.
REQ-011 grant_n  output  2  per-master grant, one-hot-low, registered.
REQ-012 timeout  output  1  one-cycle pulse on bus-grant timeout.

Function
REQ-013 bg_n, as_n, dtack_n and bgack_in_n SHALL pass through SYNC_STAGES-flop synchronizers before use; all timing below uses the synchronized values.
REQ-014 FSM states SHALL be IDLE, REQUEST, WAIT_BUS, OWN, RELEASE.
REQ-015 IDLE: if any req_n is low, latch the winner and go to REQUEST next cycle.
REQ-016 Winner selection SHALL be round-robin: on simultaneous requests, the master not granted last wins; last_grant resets to 1, so master 0 wins the first tie.
REQ-017 REQUEST: br_n low, load counter with 0; when bg_n goes low, go to WAIT_BUS.
REQ-018 REQUEST: if the counter reaches BG_TIMEOUT, release br_n, pulse timeout for 1 cycle and go to IDLE; the winner is not recorded as last_grant.
REQ-019 REQUEST: if the latched winner's req_n rises, release br_n and go to IDLE with no grant.
REQ-020 WAIT_BUS: br_n stays low; go to OWN on the first cycle where as_n, dtack_n and bgack_in_n are all high.
REQ-021 WAIT_BUS: if bg_n returns high, go back to REQUEST and reset the counter.
REQ-022 OWN: bgack_n low, br_n Z, grant_n[winner] low, all on the same registered edge; update last_grant.
REQ-023 OWN: the winner's req_n rising SHALL cause exit to RELEASE; the other requester is ignored until then, with no preemption.
REQ-024 RELEASE: grant_n all high and bgack_n Z for exactly 1 cycle, then IDLE; a pending request re-arbitrates in IDLE the next cycle.
REQ-025 br_n and bgack_n SHALL never be low in the same cycle except the first OWN cycle is excluded; br_n is Z in OWN.
REQ-026 At most one grant_n bit SHALL be low at any time.
REQ-027 Counter SHALL be 16 bits and saturate, never wrap; BG_TIMEOUT must be at most 65535.

Reset
REQ-028 por_n low SHALL asynchronously force IDLE, br_n Z, bgack_n Z, grant_n 2'b11, timeout 0, counter 0, last_grant 1, synchronizers to 1.
REQ-029 Reset asserted in OWN SHALL release the bus immediately, with no RELEASE cycle.
REQ-030 After por_n rises, the first arbitration SHALL occur no earlier than SYNC_STAGES cycles later.

Structure
REQ-031 Shared package holds the state encoding (3-bit, 5 states) and the BG_TIMEOUT and SYNC_STAGES defaults.
REQ-032 One sub-module, sync_ff: a parameterized-depth single-bit synchronizer with reset value 1, instantiated 4 times.
REQ-033 Tri-state drivers SHALL exist only at the top-level outputs; internal signals are 2-state.

Verification
REQ-034 req_n=2'b10; bg_n low 3 cycles after br_n; as_n, dtack_n high -> bgack_n low and grant_n=2'b10 no later than SYNC_STAGES+2 cycles after bg_n; req_n[0] high -> grant_n=2'b11 and bgack_n Z within 2 cycles.
REQ-035 req_n=2'b00 held through three tenures (each master releasing after 10 cycles, re-requesting 1 cycle later) -> grant order 0,1,0.
REQ-036 req_n=2'b10, bg_n held high, BG_TIMEOUT=20 -> br_n low 20 cycles, then Z, timeout pulses once, FSM IDLE, then re-requests.
REQ-037 bg_n low while as_n low for 5 cycles -> no bgack_n until 1 cycle after as_n, dtack_n and bgack_in_n are all synchronized high.
REQ-038 por_n pulsed low in OWN -> same-cycle bgack_n Z, br_n Z, grant_n=2'b11.
REQ-039 bg_n deasserted in WAIT_BUS -> return to REQUEST, counter restarts, no grant issued.
